studio2_bus_arbiter: RTL

STUDIO2_BUS_ARBITER -- requirements
Module: studio2_bus_arbiter

---
 rtl/studio2_bus_arbiter_pkg.sv | 36 +++
 rtl/studio2_addr_decode.sv | 36 +++
 rtl/studio2_bus_arbiter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/studio2_bus_arbiter_pkg.sv
// rtl/studio2_bus_arbiter_pkg.sv - shared enums and address map for the Studio II bus arbiter
// Purpose: region/owner/state encodings and the 16-bit address map used by
//          studio2_addr_decode and studio2_bus_arbiter.
// Ports:   none (package).
package studio2_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    REGION_ROM  = 2'd0,
    REGION_CART = 2'd1,
    REGION_RAM  = 2'd2,
    REGION_NONE = 2'd3
  } region_e;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_CPU  = 2'd1,
    OWNER_DMA  = 2'd2,
    OWNER_LD   = 2'd3
  } owner_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  // Address map: ROM, cartridge, 512-byte RAM window, unmapped hole above RAM.
  localparam logic [15:0] ROM_BASE  = 16'h0000;
  localparam logic [15:0] CART_BASE = 16'h0400;
  localparam logic [15:0] RAM_BASE  = 16'h0800;
  localparam logic [15:0] RAM_END   = 16'h0A00;

  localparam logic [7:0] RDATA_IDLE = 8'hFF;
  localparam logic [2:0] STARVE_MAX = 3'd7;

endpackage

// File: rtl/studio2_addr_decode.sv
// rtl/studio2_addr_decode.sv - combinational 16-bit address to region/offset decoder
// Purpose: map a requester address onto the physical memory regions.
// Ports:   addr   in  16  requester address
//          region out 2   region_e encoding (ROM/CART/RAM/NONE)
//          offset out 10  word offset inside the region (0 for NONE)
module studio2_addr_decode
  import studio2_bus_arbiter_pkg::*;
(
  input  logic [15:0] addr,
  output logic [1:0]  region,
  output logic [9:0]  offset
);

  localparam logic [11:0] CART_LO  = CART_BASE[11:0];
  localparam logic [11:0] RAM_LO   = RAM_BASE[11:0];
  localparam logic [9:0]  RAM_SPAN = 10'(RAM_END - RAM_BASE);

  always_comb begin
    region = REGION_NONE;
    offset = '0;
    if (addr[15:12] == 4'h0) begin
      if (addr[11:0] < CART_LO) begin
        region = REGION_ROM;
        offset = addr[9:0];
      end else if (addr[11:0] < RAM_LO) begin
        region = REGION_CART;
        offset = addr[9:0];
      end else if (addr[9:0] < RAM_SPAN) begin
        // Both 0x800 and 0xC00 land here: the RAM window repeats every 1K.
        region = REGION_RAM;
        offset = {1'b0, addr[8:0]};
      end
    end
  end

endmodule

// File: rtl/studio2_bus_arbiter.sv
// rtl/studio2_bus_arbiter.sv - three-way CPU/DMA/loader arbiter onto one memory bus
// Purpose: arbitrate CPU, video DMA and cartridge loader onto a single
//          ADDR/DATA memory bus with CPU starvation promotion.
// Ports:   clk, resetq                      clock, sync active-low reset
//          cpu_req/we/addr/wdata, cpu_ack/rdata   CPU port
//          dma_req/addr, dma_ack/rdata      video DMA read port
//          ld_active/req/addr/data, ld_ack  cartridge loader write port
//          mem_ce/we/region/addr/wdata, mem_rdata  memory bus
//          cpu_starved                      CPU promotion pending
module studio2_bus_arbiter
  import studio2_bus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  input  logic        dma_req,
  input  logic [15:0] dma_addr,
  output logic        dma_ack,
  output logic [7:0]  dma_rdata,
  input  logic        ld_active,
  input  logic        ld_req,
  input  logic [9:0]  ld_addr,
  input  logic [7:0]  ld_data,
  output logic        ld_ack,
  output logic        mem_ce,
  output logic        mem_we,
  output logic [1:0]  mem_region,
  output logic [9:0]  mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        cpu_starved
);

  // Limit clamped into the compare width; a limit above 7 can never be reached.
  localparam int         LIMIT_SAT = (STARVE_LIMIT > 8) ? 8 : ((STARVE_LIMIT < 0) ? 0 : STARVE_LIMIT);
  localparam logic [3:0] LIMIT4    = LIMIT_SAT[3:0];

  state_e      r_state;
  owner_e      r_grant;
  owner_e      r_owner;
  logic        r_none;
  logic [2:0]  r_starve_cnt;

  state_e      w_state_nxt;
  owner_e      w_grant_nxt;
  owner_e      w_arb_grant;
  logic [2:0]  w_starve_nxt;
  logic        w_decide;
  logic        w_starved;
  logic        w_ld_elig;
  logic        w_cpu_elig;

  logic [1:0]  w_cpu_region;
  logic [9:0]  w_cpu_off;
  logic [1:0]  w_dma_region;
  logic [9:0]  w_dma_off;
  logic [15:0] w_ld_addr16;
  logic [1:0]  w_ld_region;
  logic [9:0]  w_ld_off;

  logic [1:0]  w_sel_region;
  logic [9:0]  w_sel_off;
  logic        w_sel_we;
  logic [7:0]  w_sel_wdata;

  // The loader only ever targets the cartridge, so its 10-bit address is
  // placed inside the cartridge window before decoding.
  assign w_ld_addr16 = CART_BASE | {6'b0, ld_addr};

  studio2_addr_decode u_dec_cpu (
    .addr   (cpu_addr),
    .region (w_cpu_region),
    .offset (w_cpu_off)
  );

  studio2_addr_decode u_dec_dma (
    .addr   (dma_addr),
    .region (w_dma_region),
    .offset (w_dma_off)
  );

  studio2_addr_decode u_dec_ld (
    .addr   (w_ld_addr16),
    .region (w_ld_region),
    .offset (w_ld_off)
  );

  // Arbitration ---------------------------------------------------------

  assign w_decide   = (r_state == ST_IDLE) || (r_state == ST_DATA);
  assign w_starved  = ({1'b0, r_starve_cnt} >= LIMIT4);
  assign w_ld_elig  = ld_req & ld_active;
  assign w_cpu_elig = cpu_req & ~ld_active;
  assign cpu_starved = w_starved;

  always_comb begin
    w_arb_grant = OWNER_NONE;
    if (w_ld_elig)
      w_arb_grant = OWNER_LD;
    else if (w_starved && w_cpu_elig)
      w_arb_grant = OWNER_CPU;
    else if (dma_req)
      w_arb_grant = OWNER_DMA;
    else if (w_cpu_elig)
      w_arb_grant = OWNER_CPU;
  end

  // Starvation counts lost decisions only; a held-off CPU during a download
  // keeps its count so it is promoted as soon as the download ends.
  always_comb begin
    w_starve_nxt = r_starve_cnt;
    if (!cpu_req) begin
      w_starve_nxt = '0;
    end else if (w_decide && (w_arb_grant != OWNER_NONE)) begin
      if (w_arb_grant == OWNER_CPU)
        w_starve_nxt = '0;
      else if (!ld_active && (r_starve_cnt != STARVE_MAX))
        w_starve_nxt = r_starve_cnt + 3'd1;
    end
  end

  // Address-phase mux from the granted requester --------------------------

  always_comb begin
    w_sel_region = REGION_NONE;
    w_sel_off    = '0;
    w_sel_we     = 1'b0;
    w_sel_wdata  = '0;
    case (r_grant)
      OWNER_CPU: begin
        w_sel_region = w_cpu_region;
        w_sel_off    = w_cpu_off;
        // Writes to ROM/CART from the CPU are silently dropped.
        w_sel_we     = cpu_we && (w_cpu_region == REGION_RAM);
        w_sel_wdata  = cpu_wdata;
      end
      OWNER_DMA: begin
        w_sel_region = w_dma_region;
        w_sel_off    = w_dma_off;
      end
      OWNER_LD: begin
        w_sel_region = w_ld_region;
        w_sel_off    = w_ld_off;
        w_sel_we     = 1'b1;
        w_sel_wdata  = ld_data;
      end
      default: begin
        w_sel_region = REGION_NONE;
      end
    endcase
  end

  // FSM -------------------------------------------------------------------

  always_ff @(posedge clk) begin
    if (!resetq) begin
      r_state <= ST_IDLE;
      r_grant <= OWNER_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    mem_ce      = 1'b0;
    mem_we      = 1'b0;
    mem_region  = REGION_NONE;
    mem_addr    = '0;
    mem_wdata   = '0;
    cpu_ack     = 1'b0;
    dma_ack     = 1'b0;
    ld_ack      = 1'b0;
    cpu_rdata   = RDATA_IDLE;
    dma_rdata   = RDATA_IDLE;
    case (r_state)
      ST_IDLE, ST_DATA: begin
        w_grant_nxt = w_arb_grant;
        w_state_nxt = (w_arb_grant != OWNER_NONE) ? ST_ADDR : ST_IDLE;
        if (r_state == ST_DATA) begin
          // Acks are qualified by resetq so a transaction being aborted by
          // reset in its data cycle never reports completion.
          cpu_ack = resetq && (r_owner == OWNER_CPU);
          dma_ack = resetq && (r_owner == OWNER_DMA);
          ld_ack  = resetq && (r_owner == OWNER_LD);
          if (r_owner == OWNER_CPU && !r_none) cpu_rdata = mem_rdata;
          if (r_owner == OWNER_DMA && !r_none) dma_rdata = mem_rdata;
        end
      end
      ST_ADDR: begin
        w_state_nxt = ST_DATA;
        mem_region  = w_sel_region;
        if (w_sel_region != REGION_NONE) begin
          mem_ce    = 1'b1;
          mem_we    = w_sel_we;
          mem_addr  = w_sel_off;
          mem_wdata = w_sel_we ? w_sel_wdata : 8'h00;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = OWNER_NONE;
      end
    endcase
  end

  // Data-phase bookkeeping ------------------------------------------------

  always_ff @(posedge clk) begin
    if (!resetq) begin
      r_owner      <= OWNER_NONE;
      r_none       <= 1'b1;
      r_starve_cnt <= '0;
    end else begin
      if (r_state == ST_ADDR) begin
        r_owner <= r_grant;
        r_none  <= (w_sel_region == REGION_NONE);
      end
      r_starve_cnt <= w_starve_nxt;
    end
  end

endmodule
